// File: rtl/shader_pkg.sv
// Shared types and field layout for the face_fetch -> shader front end.
package shader_pkg;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_F,
    S_LATCH_F,
    S_FETCH_V,
    S_START,
    S_WAIT_DONE
  } state_t;

  // Default vertex index width (vertex table depth is 2**VIDX_W).
  localparam int VIDX_W_DEF = 10;

  localparam int COORD_W = 16;
  localparam int COLOR_W = 16;
  localparam int VERT_W  = 3 * COORD_W;

  // Face word: {color[15:0], i3, i2, i1}, with offsets for the default index width.
  localparam int I1_LSB    = 0;
  localparam int I2_LSB    = VIDX_W_DEF;
  localparam int I3_LSB    = 2 * VIDX_W_DEF;
  localparam int COLOR_LSB = 3 * VIDX_W_DEF;

  // Vertex word: {x, y, z}.
  localparam int X_LSB = 32;
  localparam int Y_LSB = 16;
  localparam int Z_LSB = 0;

endpackage

// File: rtl/face_fetch.sv
// face_fetch: walks the face table once per frame request, fetches the three
// vertices of each face from the vertex table, hands them plus the face colour
// to the shader, pulses start and waits for done before the next face.
module face_fetch
  import shader_pkg::*;
#(
  parameter  int N_FACES = 32,
  parameter  int VIDX_W  = VIDX_W_DEF,
  localparam int FIDX_W  = (N_FACES > 1) ? $clog2(N_FACES) : 1,
  localparam int FACE_W  = COLOR_W + 3 * VIDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic [FIDX_W-1:0] face_addr,
  input  logic [FACE_W-1:0] face_rdata,
  output logic [VIDX_W-1:0] vert_addr,
  input  logic [VERT_W-1:0] vert_rdata,
  output logic [15:0]       v1x,
  output logic [15:0]       v1y,
  output logic [15:0]       v1z,
  output logic [15:0]       v2x,
  output logic [15:0]       v2y,
  output logic [15:0]       v2z,
  output logic [15:0]       v3x,
  output logic [15:0]       v3y,
  output logic [15:0]       v3z,
  output logic [15:0]       pixel_color,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              frame_done
);

  // Face-word field offsets scaled to the instance's index width.
  localparam int F_I1  = I1_LSB;
  localparam int F_I2  = F_I1 + VIDX_W;
  localparam int F_I3  = F_I2 + VIDX_W;
  localparam int F_COL = F_I3 + VIDX_W;

  state_t                        state;
  logic [FIDX_W-1:0]             face_idx;
  logic [1:0]                    sub;
  logic [2:0][VIDX_W-1:0]        idx_q;    // latched i1..i3
  logic [COLOR_W-1:0]            color_q;  // latched colour, released with v3
  logic [2:0][VERT_W-1:0]        vtx;      // v1..v3 as full {x,y,z} words
  logic                          last_face;

  assign last_face = (face_idx == FIDX_W'(N_FACES - 1));

  // The face table is addressed straight from the face index register.
  assign face_addr = face_idx;

  // Frame completion is visible in the cycle the final done is sampled.
  assign frame_done = !reset && (state == S_WAIT_DONE) && done && last_face;

  assign v1x = vtx[0][X_LSB +: COORD_W];
  assign v1y = vtx[0][Y_LSB +: COORD_W];
  assign v1z = vtx[0][Z_LSB +: COORD_W];
  assign v2x = vtx[1][X_LSB +: COORD_W];
  assign v2y = vtx[1][Y_LSB +: COORD_W];
  assign v2z = vtx[1][Z_LSB +: COORD_W];
  assign v3x = vtx[2][X_LSB +: COORD_W];
  assign v3y = vtx[2][Y_LSB +: COORD_W];
  assign v3z = vtx[2][Z_LSB +: COORD_W];

  // Vertex address is a pure decode of registered state: i1, i2, i3 on sub 0..2.
  always_comb begin
    vert_addr = '0;
    if (state == S_FETCH_V) begin
      case (sub)
        2'd0:    vert_addr = idx_q[0];
        2'd1:    vert_addr = idx_q[1];
        2'd2:    vert_addr = idx_q[2];
        default: vert_addr = '0;
      endcase
    end
  end

  // Fetch sequencer; vertex data lags its address by one cycle, hence capture on sub 1..3.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      face_idx    <= '0;
      sub         <= '0;
      idx_q       <= '0;
      color_q     <= '0;
      vtx         <= '0;
      pixel_color <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            face_idx <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH_F;
          end
        end
        S_FETCH_F: state <= S_LATCH_F;
        S_LATCH_F: begin
          idx_q[0] <= face_rdata[F_I1 +: VIDX_W];
          idx_q[1] <= face_rdata[F_I2 +: VIDX_W];
          idx_q[2] <= face_rdata[F_I3 +: VIDX_W];
          color_q  <= face_rdata[F_COL +: COLOR_W];
          sub      <= '0;
          state    <= S_FETCH_V;
        end
        S_FETCH_V: begin
          sub <= sub + 2'd1;
          case (sub)
            2'd1: vtx[0] <= vert_rdata;
            2'd2: vtx[1] <= vert_rdata;
            2'd3: begin
              vtx[2]      <= vert_rdata;
              pixel_color <= color_q;
              start       <= 1'b1;
              state       <= S_START;
            end
            default: ;
          endcase
        end
        S_START: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (done) begin
            if (last_face) begin
              face_idx <= '0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              face_idx <= face_idx + FIDX_W'(1);
              state    <= S_FETCH_F;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_face_fetch.sv
// Directed bench for face_fetch: a single-face instance and a four-face
// instance share clock, reset and a vertex table; each has its own face table.
module tb_face_fetch;
  import shader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // single-face instance
  logic        frame_start_a = 1'b0, done_a = 1'b0;
  logic [0:0]  face_addr_a;
  logic [45:0] face_rdata_a;
  logic [9:0]  vert_addr_a;
  logic [47:0] vert_rdata_a;
  logic [15:0] v1x_a, v1y_a, v1z_a, v2x_a, v2y_a, v2z_a, v3x_a, v3y_a, v3z_a, pix_a;
  logic        start_a, busy_a, frame_done_a;

  // four-face instance
  logic        frame_start_b = 1'b0, done_b = 1'b0;
  logic [1:0]  face_addr_b;
  logic [45:0] face_rdata_b;
  logic [9:0]  vert_addr_b;
  logic [47:0] vert_rdata_b;
  logic [15:0] v1x_b, v1y_b, v1z_b, v2x_b, v2y_b, v2z_b, v3x_b, v3y_b, v3z_b, pix_b;
  logic        start_b, busy_b, frame_done_b;

  logic [45:0] fmem_a [0:1];
  logic [45:0] fmem_b [0:3];
  logic [47:0] vmem   [0:1023];

  int pass_cnt = 0;
  int total_cnt = 0;

  face_fetch #(.N_FACES(1), .VIDX_W(10)) u_a (
    .clk(clk), .reset(reset), .frame_start(frame_start_a),
    .face_addr(face_addr_a), .face_rdata(face_rdata_a),
    .vert_addr(vert_addr_a), .vert_rdata(vert_rdata_a),
    .v1x(v1x_a), .v1y(v1y_a), .v1z(v1z_a), .v2x(v2x_a), .v2y(v2y_a), .v2z(v2z_a),
    .v3x(v3x_a), .v3y(v3y_a), .v3z(v3z_a), .pixel_color(pix_a),
    .start(start_a), .done(done_a), .busy(busy_a), .frame_done(frame_done_a));

  face_fetch #(.N_FACES(4), .VIDX_W(10)) u_b (
    .clk(clk), .reset(reset), .frame_start(frame_start_b),
    .face_addr(face_addr_b), .face_rdata(face_rdata_b),
    .vert_addr(vert_addr_b), .vert_rdata(vert_rdata_b),
    .v1x(v1x_b), .v1y(v1y_b), .v1z(v1z_b), .v2x(v2x_b), .v2y(v2y_b), .v2z(v2z_b),
    .v3x(v3x_b), .v3y(v3y_b), .v3z(v3z_b), .pixel_color(pix_b),
    .start(start_b), .done(done_b), .busy(busy_b), .frame_done(frame_done_b));

  // synchronous-read tables, one cycle of latency
  always @(posedge clk) begin
    face_rdata_a <= fmem_a[face_addr_a];
    face_rdata_b <= fmem_b[face_addr_b];
    vert_rdata_a <= vmem[vert_addr_a];
    vert_rdata_b <= vmem[vert_addr_b];
  end

  function automatic logic [45:0] mkface(input logic [15:0] c, input logic [9:0] i1,
                                         input logic [9:0] i2, input logic [9:0] i3);
    logic [45:0] f;
    f = '0;
    f[COLOR_LSB +: 16] = c;
    f[I3_LSB +: 10] = i3;
    f[I2_LSB +: 10] = i2;
    f[I1_LSB +: 10] = i1;
    return f;
  endfunction

  function automatic logic [47:0] mkvert(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
    logic [47:0] w;
    w = '0;
    w[X_LSB +: 16] = x;
    w[Y_LSB +: 16] = y;
    w[Z_LSB +: 16] = z;
    return w;
  endfunction

  function automatic logic [159:0] outs_a();
    return {v1x_a, v1y_a, v1z_a, v2x_a, v2y_a, v2z_a, v3x_a, v3y_a, v3z_a, pix_a};
  endfunction

  function automatic logic [159:0] outs_b();
    return {v1x_b, v1y_b, v1z_b, v2x_b, v2y_b, v2z_b, v3x_b, v3y_b, v3z_b, pix_b};
  endfunction

  // expected shader-facing values for a face word: {vtx[i1], vtx[i2], vtx[i3], colour}
  function automatic logic [159:0] exp_face(input logic [45:0] fw);
    return {vmem[fw[I1_LSB +: 10]], vmem[fw[I2_LSB +: 10]], vmem[fw[I3_LSB +: 10]],
            fw[COLOR_LSB +: 16]};
  endfunction

  // results of the last frame_b run
  int          nst, stab_err, fd_cnt, fd_ok, extra_st;
  bit          busy_after, tmo;
  int          st_cyc [0:7];
  logic [159:0] cap   [0:7];

  // Runs one frame on instance b with a done-after-dly shader stub.
  // spur_fs: face whose WAIT_DONE gets a frame_start pulse; spur_dn: face whose START cycle sees done.
  task automatic frame_b(input int dly, input int spur_fs, input int spur_dn);
    int  wcnt, post;
    bit  waiting, ended;
    nst = 0; stab_err = 0; fd_cnt = 0; fd_ok = 0; extra_st = 0; busy_after = 1'b1; tmo = 1'b1;
    wcnt = 0; post = 0; waiting = 1'b0; ended = 1'b0;
    frame_start_b = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      done_b = 1'b0;
      frame_start_b = 1'b0;
      if (frame_done_b === 1'b1) fd_cnt++;
      if (ended) begin
        if (post == 0) busy_after = busy_b;
        if (start_b === 1'b1) extra_st++;
        post++;
        if (post == 10) begin tmo = 1'b0; break; end
      end else if (start_b === 1'b1) begin
        if (nst < 8) begin st_cyc[nst] = k; cap[nst] = outs_b(); end
        nst++;
        waiting = 1'b1;
        wcnt = 0;
        if (spur_dn == nst - 1) done_b = 1'b1;
      end else if (waiting) begin
        wcnt++;
        if (nst <= 8 && outs_b() !== cap[nst-1]) stab_err++;
        if (spur_fs == nst - 1 && wcnt == 2) frame_start_b = 1'b1;
        if (wcnt == dly) begin
          done_b = 1'b1;
          waiting = 1'b0;
          #1;
          if (frame_done_b === 1'b1) begin fd_ok++; ended = 1'b1; end
        end
      end
    end
    done_b = 1'b0;
    frame_start_b = 1'b0;
  endtask

  // Runs one frame on instance a; the stub raises done in cycle E+dk.
  task automatic run_a(input int dk, output int nstart, output int st_at,
                       output logic [159:0] capv, output bit b1, output bit fd,
                       output bit bz_fd, output bit bz_after);
    nstart = 0; st_at = -1; capv = '0; b1 = 1'b0; fd = 1'b0; bz_fd = 1'b0; bz_after = 1'b1;
    frame_start_a = 1'b1;
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clk);
      frame_start_a = 1'b0;
      done_a = 1'b0;
      if (start_a === 1'b1) begin nstart++; st_at = k; capv = outs_a(); end
      if (k == 1) b1 = busy_a;
      if (k == dk) begin
        done_a = 1'b1;
        #1;
        fd = frame_done_a;
        bz_fd = busy_a;
      end
      if (k == dk + 1) bz_after = busy_a;
    end
    done_a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_busy: got %b/%b want 0/0", busy_a, busy_b); else pass_cnt++;
    total_cnt++; if (start_a !== 1'b0 || start_b !== 1'b0) $display("FAIL reset_start: got %b/%b want 0/0", start_a, start_b); else pass_cnt++;
    total_cnt++; if (frame_done_a !== 1'b0 || frame_done_b !== 1'b0) $display("FAIL reset_frame_done: got %b/%b want 0/0", frame_done_a, frame_done_b); else pass_cnt++;
    total_cnt++; if (outs_a() !== 160'd0) $display("FAIL reset_outs_a: got %h want 0", outs_a()); else pass_cnt++;
    total_cnt++; if (outs_b() !== 160'd0) $display("FAIL reset_outs_b: got %h want 0", outs_b()); else pass_cnt++;
    total_cnt++; if (face_addr_a !== 1'b0 || face_addr_b !== 2'd0) $display("FAIL reset_face_addr: got %h/%h want 0/0", face_addr_a, face_addr_b); else pass_cnt++;
    total_cnt++; if (vert_addr_a !== 10'd0 || vert_addr_b !== 10'd0) $display("FAIL reset_vert_addr: got %h/%h want 0/0", vert_addr_a, vert_addr_b); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_idle_busy: got %b/%b want 0/0", busy_a, busy_b); else pass_cnt++;
  endtask

  task automatic test_single_face();
    int nstart, st_at;
    logic [159:0] capv;
    bit b1, fd, bz_fd, bz_after;
    run_a(20, nstart, st_at, capv, b1, fd, bz_fd, bz_after);
    total_cnt++; if (b1 !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", b1); else pass_cnt++;
    total_cnt++; if (nstart !== 1) $display("FAIL single_start_count: got %0d want 1", nstart); else pass_cnt++;
    total_cnt++; if (st_at !== 7) $display("FAIL single_start_cycle: got E+%0d want E+7", st_at); else pass_cnt++;
    total_cnt++;
    if (capv !== {48'h27fc_1b5f_0178, 48'h315f_1b57_0178, 48'h30a9_1ab2_017b, 16'h0001})
      $display("FAIL single_outputs: got %h want 27fc1b5f0178315f1b57017830a91ab2017b0001", capv);
    else pass_cnt++;
    total_cnt++; if (fd !== 1'b1) $display("FAIL single_frame_done: got %b want 1", fd); else pass_cnt++;
    total_cnt++; if (bz_fd !== 1'b1) $display("FAIL single_busy_at_done: got %b want 1", bz_fd); else pass_cnt++;
    total_cnt++; if (bz_after !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", bz_after); else pass_cnt++;
  endtask

  task automatic test_multi_face();
    frame_b(5, -1, -1);
    total_cnt++; if (tmo !== 1'b0) $display("FAIL multi_timeout: got %b want 0", tmo); else pass_cnt++;
    total_cnt++; if (nst !== 4) $display("FAIL multi_start_count: got %0d want 4", nst); else pass_cnt++;
    total_cnt++; if (st_cyc[0] !== 7) $display("FAIL multi_first_start: got E+%0d want E+7", st_cyc[0]); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (st_cyc[i+1] - st_cyc[i] !== 12) $display("FAIL multi_spacing_%0d: got %0d want 12", i, st_cyc[i+1] - st_cyc[i]); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (cap[i] !== exp_face(fmem_b[i])) $display("FAIL multi_face_%0d: got %h want %h", i, cap[i], exp_face(fmem_b[i])); else pass_cnt++;
    end
    total_cnt++; if (stab_err !== 0) $display("FAIL multi_stable: got %0d changes want 0", stab_err); else pass_cnt++;
    total_cnt++; if (fd_ok !== 1 || fd_cnt !== 0) $display("FAIL multi_frame_done: got %0d/%0d want 1/0", fd_ok, fd_cnt); else pass_cnt++;
    total_cnt++; if (busy_after !== 1'b0) $display("FAIL multi_busy_drop: got %b want 0", busy_after); else pass_cnt++;
    total_cnt++; if (extra_st !== 0) $display("FAIL multi_extra_start: got %0d want 0", extra_st); else pass_cnt++;
  endtask

  task automatic test_spurious_frame_start();
    frame_b(5, 1, -1);
    total_cnt++; if (nst !== 4 || tmo !== 1'b0) $display("FAIL spur_fs_count: got %0d starts tmo=%b want 4 tmo=0", nst, tmo); else pass_cnt++;
    total_cnt++; if (extra_st !== 0) $display("FAIL spur_fs_queued: got %0d extra starts want 0", extra_st); else pass_cnt++;
    total_cnt++; if (fd_ok !== 1 || fd_cnt !== 0) $display("FAIL spur_fs_frame_done: got %0d/%0d want 1/0", fd_ok, fd_cnt); else pass_cnt++;
  endtask

  task automatic test_done_in_start();
    frame_b(5, -1, 2);
    total_cnt++; if (nst !== 4 || tmo !== 1'b0) $display("FAIL spur_done_count: got %0d starts tmo=%b want 4 tmo=0", nst, tmo); else pass_cnt++;
    total_cnt++; if (st_cyc[3] - st_cyc[2] !== 12) $display("FAIL spur_done_spacing: got %0d want 12", st_cyc[3] - st_cyc[2]); else pass_cnt++;
    total_cnt++; if (cap[3] !== exp_face(fmem_b[3])) $display("FAIL spur_done_face3: got %h want %h", cap[3], exp_face(fmem_b[3])); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int seen, late;
    bit b29;
    logic [159:0] o29;
    logic [1:0] fa29;
    logic [9:0] va29;
    seen = 0; late = 0; b29 = 1'b1; o29 = '1; fa29 = '1; va29 = '1;
    frame_start_b = 1'b1;
    // faces 0/1 start at E+7/E+19, done in E+12/E+24; face 2 is in FETCH_V over E+27..E+30
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      frame_start_b = 1'b0;
      done_b = 1'b0;
      reset = 1'b0;
      if (start_b === 1'b1 && (k == 7 || k == 19)) seen++;
      if (k >= 29 && (start_b !== 1'b0 || frame_done_b !== 1'b0)) late++;
      if (k == 29) begin b29 = busy_b; o29 = outs_b(); fa29 = face_addr_b; va29 = vert_addr_b; end
      if (k == 12 || k == 24) done_b = 1'b1;
      if (k == 28) reset = 1'b1;
    end
    total_cnt++; if (seen !== 2) $display("FAIL rst_mid_pre_starts: got %0d want 2", seen); else pass_cnt++;
    total_cnt++; if (b29 !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", b29); else pass_cnt++;
    total_cnt++; if (o29 !== 160'd0) $display("FAIL rst_mid_outs: got %h want 0", o29); else pass_cnt++;
    total_cnt++; if (fa29 !== 2'd0 || va29 !== 10'd0) $display("FAIL rst_mid_addr: got %h/%h want 0/0", fa29, va29); else pass_cnt++;
    total_cnt++; if (late !== 0) $display("FAIL rst_mid_late_events: got %0d want 0", late); else pass_cnt++;
    frame_b(5, -1, -1);
    total_cnt++; if (nst !== 4 || tmo !== 1'b0) $display("FAIL rst_mid_restart_count: got %0d tmo=%b want 4 tmo=0", nst, tmo); else pass_cnt++;
    total_cnt++; if (cap[0] !== exp_face(fmem_b[0])) $display("FAIL rst_mid_restart_face0: got %h want %h", cap[0], exp_face(fmem_b[0])); else pass_cnt++;
  endtask

  task automatic test_duplicate();
    int nstart, st_at;
    logic [159:0] capv;
    bit b1, fd, bz_fd, bz_after;
    fmem_a[0] = mkface(16'habcd, 10'd5, 10'd5, 10'd5);
    run_a(10, nstart, st_at, capv, b1, fd, bz_fd, bz_after);
    total_cnt++; if (nstart !== 1 || st_at !== 7) $display("FAIL dup_start: got %0d at E+%0d want 1 at E+7", nstart, st_at); else pass_cnt++;
    total_cnt++;
    if (capv !== {48'h1234_5678_9abc, 48'h1234_5678_9abc, 48'h1234_5678_9abc, 16'habcd})
      $display("FAIL dup_outputs: got %h want 123456789abc x3 + abcd", capv);
    else pass_cnt++;
    total_cnt++; if (fd !== 1'b1 || bz_after !== 1'b0) $display("FAIL dup_frame_end: got fd=%b busy=%b want 1/0", fd, bz_after); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) vmem[i] = '0;
    vmem[0] = mkvert(16'h27fc, 16'h1b5f, 16'h0178);
    vmem[1] = mkvert(16'h315f, 16'h1b57, 16'h0178);
    vmem[2] = mkvert(16'h30a9, 16'h1ab2, 16'h017b);
    vmem[3] = mkvert(16'h0003, 16'h0033, 16'h0333);
    vmem[5] = mkvert(16'h1234, 16'h5678, 16'h9abc);
    vmem[7] = mkvert(16'h0707, 16'h7070, 16'h7777);
    vmem[9] = mkvert(16'h0909, 16'h9090, 16'h9999);
    fmem_a[0] = mkface(16'h0001, 10'd0, 10'd1, 10'd2);
    fmem_a[1] = '0;
    fmem_b[0] = mkface(16'h00f0, 10'd0, 10'd1, 10'd2);
    fmem_b[1] = mkface(16'h0f00, 10'd3, 10'd5, 10'd7);
    fmem_b[2] = mkface(16'hf000, 10'd9, 10'd7, 10'd5);
    fmem_b[3] = mkface(16'h000f, 10'd2, 10'd9, 10'd3);

    test_reset();
    test_single_face();
    test_multi_face();
    test_spurious_frame_start();
    test_done_in_start();
    test_reset_mid();
    test_duplicate();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
